// File: rtl/vector_load_handler_if.sv
// Bus bundle for vector_load_handler.
// slave  : the load handler. It takes the request and memory read data, and
//          drives the memory address, the stall and the writeback data.
// master : the pipeline/memory side. It drives the request and read data.
// Signals:
//   Address, Vectorop, ReadEn   load request
//   MemoryDataRead              data returned by data memory
//   Out_Address                 registered read address to memory
//   BlockPipeLd                 pipeline stall
//   VectorData, VectorValid     assembled vector and its completion pulse
//   ScalarData, ScalarValid     scalar load data and its valid pulse
interface vector_load_handler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16,
    parameter int ADDR_WIDTH = 19
);
    logic [ADDR_WIDTH-1:0]             Address;
    logic                              Vectorop;
    logic                              ReadEn;
    logic [DATA_WIDTH-1:0]             MemoryDataRead;
    logic [ADDR_WIDTH-1:0]             Out_Address;
    logic                              BlockPipeLd;
    logic [LANES-1:0][DATA_WIDTH-1:0]  VectorData;
    logic                              VectorValid;
    logic [DATA_WIDTH-1:0]             ScalarData;
    logic                              ScalarValid;

    modport master (
        output Address, Vectorop, ReadEn, MemoryDataRead,
        input  Out_Address, BlockPipeLd, VectorData, VectorValid,
               ScalarData, ScalarValid
    );

    modport slave (
        input  Address, Vectorop, ReadEn, MemoryDataRead,
        output Out_Address, BlockPipeLd, VectorData, VectorValid,
               ScalarData, ScalarValid
    );
endinterface

// File: rtl/vector_load_handler.sv
// Memory-stage load handler.
// A vector load issues LANES consecutive word reads from a latched base
// address, collects the returned words into VectorData lane by lane, and
// stalls the pipeline until the vector is complete. A scalar load is a single
// non-stalling read whose data is passed straight through.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  vector_load_handler_if.slave (request, memory port, writeback)

// One vector lane register, written when its capture slot comes up.
module vlh_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
    end
endmodule

module vector_load_handler #(
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 16,
    parameter int ADDR_WIDTH  = 19,
    parameter int MEM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    vector_load_handler_if.slave   bus
);
    localparam int CW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                            state;
    logic [ADDR_WIDTH-1:0]             base;
    logic [ADDR_WIDTH-1:0]             out_addr;
    logic [CW-1:0]                     issue_cnt;
    logic [CW-1:0]                     cap_cnt;
    logic                              vec_valid;
    // Bit 0 marks a read whose address was just registered; bit MEM_LATENCY
    // marks that its data is on MemoryDataRead this cycle. Vector-lane reads
    // and scalar reads are tagged in separate pipes so an in-flight scalar
    // is never captured as a lane.
    logic [MEM_LATENCY:0]              vld_pipe;
    logic [MEM_LATENCY:0]              sld_pipe;
    logic [LANES-1:0][DATA_WIDTH-1:0]  lane_q;

    logic accept_vec, accept_sc, issue_vec, cap, last_cap;

    assign accept_vec = (state == IDLE) && bus.ReadEn && bus.Vectorop;
    assign accept_sc  = (state == IDLE) && bus.ReadEn && !bus.Vectorop;
    assign issue_vec  = accept_vec || (state == ISSUE);
    assign cap        = vld_pipe[MEM_LATENCY];
    assign last_cap   = cap && (cap_cnt == CW'(LANES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            base      <= '0;
            out_addr  <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            vec_valid <= 1'b0;
            vld_pipe  <= '0;
            sld_pipe  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[MEM_LATENCY-1:0], issue_vec};
            sld_pipe  <= {sld_pipe[MEM_LATENCY-1:0], accept_sc};
            vec_valid <= 1'b0;
            // LANES is a power of two, so the counter returns to 0 after
            // the last lane without an explicit clear.
            if (cap) cap_cnt <= cap_cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (accept_vec) begin
                        base      <= bus.Address;
                        out_addr  <= bus.Address;
                        issue_cnt <= CW'(1);
                        state     <= ISSUE;
                    end else if (accept_sc) begin
                        out_addr  <= bus.Address;
                    end
                end
                ISSUE: begin
                    // Address arithmetic wraps modulo 2^ADDR_WIDTH.
                    out_addr  <= base + ADDR_WIDTH'(issue_cnt);
                    issue_cnt <= issue_cnt + CW'(1);
                    if (issue_cnt == CW'(LANES - 1)) state <= DRAIN;
                end
                DRAIN: begin
                    // The last lane is always captured here: its read is
                    // issued at the ISSUE->DRAIN edge.
                    if (last_cap) begin
                        state     <= DONE;
                        vec_valid <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic en;
        assign en = cap && (cap_cnt == CW'(i));
        vlh_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (bus.MemoryDataRead),
            .q   (lane_q[i])
        );
    end

    assign bus.Out_Address = out_addr;
    assign bus.VectorData  = lane_q;
    assign bus.VectorValid = vec_valid;
    assign bus.ScalarData  = bus.MemoryDataRead;
    assign bus.ScalarValid = sld_pipe[MEM_LATENCY];
    // The stall includes the accept cycle itself and drops in DONE, so the
    // pipeline advances exactly with VectorValid. It is held low in reset.
    assign bus.BlockPipeLd = rst && ((state == ISSUE) || (state == DRAIN) || accept_vec);
endmodule

// File: tb/tb_vector_load_handler.sv
// Bench for vector_load_handler: two instances (memory latency 1 and 3),
// each with its own memory model returning mem[a] = a[15:0].
module tb_vector_load_handler;
    localparam int DW = 16;
    localparam int LN = 16;
    localparam int AW = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][AW-1:0]         addr_in;
    logic [1:0]                 vop, ren;
    logic [1:0][AW-1:0]         oaddr;
    logic [1:0]                 bp, vv, sv;
    logic [1:0][LN-1:0][DW-1:0] vdata;
    logic [1:0][DW-1:0]         sdata;

    int lat_of [2] = '{1, 3};
    logic [AW-1:0] model_addr [2];
    int n_chk = 0;
    int n_fail = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int LAT = (gi == 0) ? 1 : 3;
        vector_load_handler_if #(.DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW)) bus ();
        // Address seen at edge k is answered during the cycle after E(k+LAT).
        logic [AW-1:0] hist [LAT];
        always @(posedge clk) begin
            hist[0] <= bus.Out_Address;
            for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
        end
        assign bus.Address        = addr_in[gi];
        assign bus.Vectorop       = vop[gi];
        assign bus.ReadEn         = ren[gi];
        assign bus.MemoryDataRead = hist[LAT-1][DW-1:0];
        vector_load_handler #(
            .DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)
        ) dut (
            .clk (clk),
            .rst (rst_n),
            .bus (bus)
        );
        assign oaddr[gi] = bus.Out_Address;
        assign bp[gi]    = bus.BlockPipeLd;
        assign vv[gi]    = bus.VectorValid;
        assign sv[gi]    = bus.ScalarValid;
        assign vdata[gi] = bus.VectorData;
        assign sdata[gi] = bus.ScalarData;
    end

    function automatic logic [DW-1:0] mem(logic [AW-1:0] a);
        return a[DW-1:0];
    endfunction

    task automatic chk(string nm, int gi, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [inst%0d] got %0h expected %0h at %0t", nm, gi, act, exp, $time);
        end
    endtask

    // Vector load on instance gi; optional scalar issued the cycle before,
    // optional random input perturbation while the load is busy.
    task automatic do_vector(input int gi, input logic [AW-1:0] b, input bit pre, input bit pert,
                             output int stall, output logic [AW-1:0] last,
                             output logic [DW-1:0] l0, output logic [DW-1:0] lN);
        int L = lat_of[gi];
        logic [AW-1:0] ea;
        logic [AW-1:0] sa;
        stall = 0;
        l0 = '0;
        lN = '0;
        sa = AW'($urandom);
        @(posedge clk); #1;
        if (pre) begin
            ren[gi] = 1'b1; vop[gi] = 1'b0; addr_in[gi] = sa;
            @(negedge clk);
            chk("pre_scalar_stall", gi, 64'(bp[gi]), 64'(0));
            @(posedge clk); #1;
        end
        ren[gi] = 1'b1; vop[gi] = 1'b1; addr_in[gi] = b;
        @(negedge clk);
        chk("accept_stall", gi, 64'(bp[gi]), 64'(1));
        if (bp[gi]) stall++;
        for (int k = 0; k <= LN + L + 1; k++) begin
            @(posedge clk); #1;
            if (pert && k <= LN + L) begin
                addr_in[gi] = (k == 0) ? 19'h12345 : AW'($urandom);
                ren[gi] = (k == 0) ? 1'b0 : 1'($urandom);
                vop[gi] = 1'($urandom);
            end else begin
                ren[gi] = 1'b0; vop[gi] = 1'b0;
            end
            @(negedge clk);
            ea = b + AW'((k < LN) ? k : LN - 1);
            chk("out_addr", gi, 64'(oaddr[gi]), 64'(ea));
            chk("stall", gi, 64'(bp[gi]), 64'(k < LN + L));
            chk("vector_valid", gi, 64'(vv[gi]), 64'(k == LN + L));
            chk("scalar_valid", gi, 64'(sv[gi]), 64'(pre && k == L - 1));
            if (pre && k == L - 1) chk("pre_scalar_data", gi, 64'(sdata[gi]), 64'(mem(sa)));
            if (bp[gi]) stall++;
            if (k == LN + L) begin
                for (int i = 0; i < LN; i++)
                    chk($sformatf("lane%0d", i), gi, 64'(vdata[gi][i]), 64'(mem(b + AW'(i))));
                l0 = vdata[gi][0];
                lN = vdata[gi][LN-1];
            end
        end
        last = oaddr[gi];
        model_addr[gi] = b + AW'(LN - 1);
    endtask

    // n back-to-back scalar loads, first at address 'first'.
    task automatic do_scalars(input int gi, input int n, input logic [AW-1:0] first);
        int L = lat_of[gi];
        logic [AW-1:0] sa [4];
        sa[0] = first;
        for (int j = 1; j < 4; j++) sa[j] = AW'($urandom);
        @(posedge clk); #1;
        ren[gi] = 1'b1; vop[gi] = 1'b0; addr_in[gi] = sa[0];
        @(negedge clk);
        chk("scalar_accept_stall", gi, 64'(bp[gi]), 64'(0));
        for (int c = 0; c <= n + L; c++) begin
            @(posedge clk); #1;
            if (c + 1 < n) addr_in[gi] = sa[c+1];
            else ren[gi] = 1'b0;
            @(negedge clk);
            chk("scalar_valid", gi, 64'(sv[gi]), 64'(c >= L && c - L < n));
            if (c >= L && c - L < n) chk("scalar_data", gi, 64'(sdata[gi]), 64'(mem(sa[c-L])));
            chk("scalar_stall", gi, 64'(bp[gi]), 64'(0));
            chk("scalar_vvalid", gi, 64'(vv[gi]), 64'(0));
            chk("scalar_out_addr", gi, 64'(oaddr[gi]), 64'(sa[(c < n) ? c : n - 1]));
        end
        model_addr[gi] = sa[n-1];
    endtask

    task automatic do_idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            for (int gi = 0; gi < 2; gi++) begin
                chk("idle_stall", gi, 64'(bp[gi]), 64'(0));
                chk("idle_vvalid", gi, 64'(vv[gi]), 64'(0));
                chk("idle_svalid", gi, 64'(sv[gi]), 64'(0));
                chk("idle_addr_hold", gi, 64'(oaddr[gi]), 64'(model_addr[gi]));
            end
        end
    endtask

    task automatic chk_reset_state(string nm);
        for (int gi = 0; gi < 2; gi++) begin
            chk({nm, "_addr"}, gi, 64'(oaddr[gi]), 64'(0));
            chk({nm, "_stall"}, gi, 64'(bp[gi]), 64'(0));
            chk({nm, "_vvalid"}, gi, 64'(vv[gi]), 64'(0));
            chk({nm, "_svalid"}, gi, 64'(sv[gi]), 64'(0));
            chk({nm, "_vdata_nonzero"}, gi, 64'(vdata[gi] != '0), 64'(0));
        end
    endtask

    typedef struct {
        int            g;
        logic [AW-1:0] base;
        bit            pre;
        bit            pert;
        int            stall;
        logic [AW-1:0] last;
        logic [DW-1:0] l0;
        logic [DW-1:0] ln;
    } vrec_t;

    vrec_t tbl [7];

    initial begin
        int st;
        logic [AW-1:0] la;
        logic [DW-1:0] l0, lN;

        tbl[0] = '{0, 19'h00100, 1'b0, 1'b0, 18, 19'h0010F, 16'h0100, 16'h010F};
        tbl[1] = '{0, 19'h7FFF8, 1'b0, 1'b0, 18, 19'h00007, 16'hFFF8, 16'h0007};
        tbl[2] = '{0, 19'h00200, 1'b0, 1'b1, 18, 19'h0020F, 16'h0200, 16'h020F};
        tbl[3] = '{0, 19'h00300, 1'b1, 1'b0, 18, 19'h0030F, 16'h0300, 16'h030F};
        tbl[4] = '{1, 19'h00100, 1'b0, 1'b0, 20, 19'h0010F, 16'h0100, 16'h010F};
        tbl[5] = '{1, 19'h00400, 1'b1, 1'b0, 20, 19'h0040F, 16'h0400, 16'h040F};
        tbl[6] = '{1, 19'h7FFF8, 1'b0, 1'b1, 20, 19'h00007, 16'hFFF8, 16'h0007};

        addr_in = '0; vop = '0; ren = '0;
        model_addr[0] = '0; model_addr[1] = '0;

        #2;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_idle(2);

        for (int i = 0; i < 7; i++) begin
            do_vector(tbl[i].g, tbl[i].base, tbl[i].pre, tbl[i].pert, st, la, l0, lN);
            chk($sformatf("tbl%0d_stall_len", i), tbl[i].g, 64'(st), 64'(tbl[i].stall));
            chk($sformatf("tbl%0d_last_addr", i), tbl[i].g, 64'(la), 64'(tbl[i].last));
            chk($sformatf("tbl%0d_lane0", i), tbl[i].g, 64'(l0), 64'(tbl[i].l0));
            chk($sformatf("tbl%0d_lane15", i), tbl[i].g, 64'(lN), 64'(tbl[i].ln));
        end

        do_scalars(0, 1, 19'h00042);
        do_scalars(0, 3, 19'h00050);
        do_scalars(1, 1, 19'h00042);
        do_scalars(1, 3, 19'h7FFFF);
        do_idle(2);

        // Reset while lanes 0..6 are captured (capture count = 7).
        @(posedge clk); #1;
        ren[0] = 1'b1; vop[0] = 1'b1; addr_in[0] = 19'h00500;
        @(posedge clk); #1;
        ren[0] = 1'b0; vop[0] = 1'b0;
        repeat (7 + lat_of[0]) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_addr[0] = '0; model_addr[1] = '0;
        do_idle(30);
        do_vector(0, 19'h00600, 1'b0, 1'b0, st, la, l0, lN);
        chk("post_reset_stall_len", 0, 64'(st), 64'(18));

        for (int it = 0; it < 24; it++) begin
            int gi = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: begin
                    do_vector(gi, AW'($urandom), 1'($urandom), 1'($urandom), st, la, l0, lN);
                    chk("rand_stall_len", gi, 64'(st), 64'(LN + lat_of[gi] + 1));
                end
                1: do_scalars(gi, int'($urandom_range(1, 4)), AW'($urandom));
                default: do_idle(int'($urandom_range(1, 3)));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vector_load_handler.md
Name: vector_load_handler

Overview:
- Memory-stage counterpart of the vector store path. It consumes the memory read port and produces register-file writeback data.
- A vector load issues LANES consecutive word reads starting at a base address. Returned words are assembled into a LANES-wide vector, and the pipeline is stalled until the vector is complete.
- A scalar load is a single non-stalling read with the data passed straight through.

Parameters:
DATA_WIDTH, 16, width of one memory word / vector lane
LANES, 16, elements per vector (power of two, 2..16)
ADDR_WIDTH, 19, memory address width
MEM_LATENCY, 1, memory read latency in cycles (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
Address  in  ADDR_WIDTH  base address (vector) or word address (scalar)
Vectorop  in  1  1 = vector load, 0 = scalar load
ReadEn  in  1  load request, qualified by Vectorop
MemoryDataRead  in  DATA_WIDTH  read data from data memory
Out_Address  out  ADDR_WIDTH  registered read address to data memory
BlockPipeLd  out  1  stall request to pipeline (combinational)
VectorData  out  LANES x DATA_WIDTH  assembled vector, lane i = mem[base+i]
VectorValid  out  1  one-cycle pulse: VectorData complete
ScalarData  out  DATA_WIDTH  scalar load data (= MemoryDataRead)
ScalarValid  out  1  one-cycle pulse: ScalarData valid

Behaviour:
- Reset (rst=0, any time, async):
  - state=IDLE; Out_Address=0; all VectorData lanes=0.
  - issue and capture counters=0; latency pipe cleared.
  - VectorValid=0, ScalarValid=0, BlockPipeLd=0.
  - A load in progress is abandoned; no partial completion pulse occurs after reset release.
- Edge numbering: E0 is the edge at which a request is accepted; Ek is the k-th edge after it.
- States:
  - IDLE: accepts requests.
  - ISSUE: addresses still being sent.
  - DRAIN: all addresses sent, data still returning.
  - DONE: one cycle, VectorValid=1.
- Vector accept (IDLE, ReadEn=1, Vectorop=1, sampled at E0):
  - Latch base=Address; Out_Address<=base; issue_cnt<=1; go to ISSUE.
- ISSUE:
  - At each edge: Out_Address<=base+issue_cnt, issue_cnt++.
  - The address for lane LANES-1 is driven at E(LANES-1); go to DRAIN at that edge.
- Address arithmetic: base+k is modulo 2^ADDR_WIDTH, so the address wraps to 0 past max.
- Memory timing: data for the address driven after Ek is present on MemoryDataRead during the cycle after E(k+MEM_LATENCY).
- Capture:
  - A MEM_LATENCY-deep valid shift pipe tracks issued reads.
  - At E(k+MEM_LATENCY+1), VectorData[capture_cnt]<=MemoryDataRead, then capture_cnt++.
  - Lanes fill strictly in order 0..LANES-1.
- DRAIN: leave at the edge that captures lane LANES-1, E(LANES+MEM_LATENCY), and go to DONE.
- DONE:
  - VectorValid=1 for exactly one cycle; VectorData is stable and complete.
  - Requests in DONE are ignored; next edge goes to IDLE.
- BlockPipeLd is 1 when:
  - state=ISSUE or state=DRAIN, or
  - state=IDLE and ReadEn and Vectorop (stall in the accept cycle itself).
- BlockPipeLd is 0 in DONE, so the pipeline advances exactly in the VectorValid cycle.
- Stall length: a vector load holds BlockPipeLd=1 for LANES+MEM_LATENCY+1 cycles. With defaults that is 18 cycles.
- Lane hold: VectorData holds the last completed vector until a new vector load captures lane 0. During a load, lanes are overwritten progressively and are valid only with VectorValid.
- Scalar load (IDLE, ReadEn=1, Vectorop=0, at E0):
  - Out_Address<=Address; no stall.
  - ScalarValid=1 during the cycle after E(MEM_LATENCY).
  - ScalarData is always MemoryDataRead, combinational.
  - Back-to-back scalar loads are allowed, one per cycle, pipelined through the same latency pipe.
- Input changes: Address, Vectorop and ReadEn changes while state is not IDLE are ignored; base stays latched.
- Scalar drain before vector: scalar reads already in flight when a vector is accepted still complete and pulse ScalarValid. They are not captured as vector lanes; the lane pipe and scalar pipe are tagged separately.
- Idle hold: Out_Address holds its last value while IDLE with no request.

Test Plan:
- Reset then vector load: Address=0x00100, MEM_LATENCY=1, memory mem[a]=a[15:0].
  - Out_Address 0x00100..0x0010F on cycles after E0..E15.
  - BlockPipeLd high 18 cycles.
  - VectorValid pulse after E17 with VectorData[i]=0x0100+i; then IDLE.
- Wrap-around: Address=0x7FFF8.
  - Out_Address sequence 0x7FFF8..0x7FFFF, 0x00000..0x00007.
  - Lanes 8..15 hold mem[0..7].
- Scalar load: Address=0x00042, Vectorop=0.
  - BlockPipeLd stays 0.
  - ScalarValid high in the cycle after E1 with ScalarData=0x0042.
  - Three back-to-back scalars give three consecutive ScalarValid pulses.
- Reset mid-operation: assert rst=0 while capture_cnt=7.
  - All outputs 0 immediately, with no clock required.
  - After release, no VectorValid pulse; a new load completes correctly.
- Input perturbation: during ISSUE, change Address to 0x12345 and drop ReadEn.
  - Sequence continues from the latched base; result is unchanged.
- MEM_LATENCY=3 build:
  - BlockPipeLd high 20 cycles; VectorValid after E19.
  - A scalar issued right before the vector pulses ScalarValid and does not corrupt lane 0.
